pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline stage registers carrying a valid bit plus a WIDTH-bit payload (PC, instruction or control bundle) from fetch towards write-back.
- Generalises the fixed per-stage PC registers:
  - STAGES and WIDTH are configurable.
  - Indexed hold with bubble insertion (load-use stall).
  - Indexed flush of younger stages (branch taken).
  - Input-side ready.
- Stage 0 is the youngest (IF/ID); stage STAGES-1 is the oldest (MEM/WB) and drives out_*.

Parameters:
- STAGES, 4, number of register stages (>=2).
- WIDTH, 32, payload width per stage.
- IDXW, $clog2(STAGES) (minimum 1), width of stage-index inputs.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  payload at in_data is valid.
- in_data  input  WIDTH  payload entering stage 0.
- in_ready  output  1  stage 0 accepts in_data this cycle.
- hold_en  input  1  stall request.
- hold_idx  input  IDXW  stages below this index hold; this stage takes a bubble.
- flush_en  input  1  flush request.
- flush_idx  input  IDXW  stages 0..flush_idx are invalidated.
- stage_valid  output  STAGES  valid bit of every stage; bit i is stage i.
- stage_data  output  STAGES*WIDTH  flattened payloads; stage i at bits [i*WIDTH +: WIDTH].
- out_valid  output  1  equals stage_valid[STAGES-1].
- out_data  output  WIDTH  equals payload of stage STAGES-1.
- retired_cnt  output  32  perf counter (see Optional Feature).
- bubble_cnt  output  32  perf counter.
- killed_cnt  output  32  perf counter.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All registers update on the clk rising edge only.
- Reset: all stage_valid=0, all stage_data=0, all counters=0. rst overrides every other input in that cycle.
- Source of stage i: stage 0 sources {in_valid, in_data}; stage i>0 sources stage i-1.
- Per-stage update each cycle, first matching rule wins:
  1. Flush: flush_en && (i <= flush_idx or flush_idx >= STAGES) -> valid<=0, data<=0.
  2. Hold: hold_en && i < hold_idx -> stage keeps its contents.
  3. Bubble: hold_en && i == hold_idx -> valid<=0, data<=0.
  4. Advance: valid<=src_valid, data<=src_valid ? src_data : 0.
- Out-of-range hold: hold_en with hold_idx >= STAGES holds every stage and inserts no bubble.
- Simultaneous flush and hold: flushed stages are cleared, and hold still applies to any stage above flush_idx that is below hold_idx.
- Latency: one cycle per stage, so an undisturbed item reaches out_* STAGES cycles after acceptance.
- in_ready = ~rst & ~hold_en & ~flush_en (combinational). When in_ready=0, in_data is not captured and the upstream source must re-present it.
- Invalid payloads are always zero, so equality checks are deterministic.
- No combinational path from in_* to out_* (not even when STAGES=2).

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined:
  - retired_cnt increments when stage STAGES-1 is valid and not held or flushed this cycle.
  - bubble_cnt increments on every cycle with hold_en && hold_idx < STAGES && !(flush_en && flush_idx >= hold_idx).
  - killed_cnt increases by the number of valid stages cleared by flush that cycle.
  - All three counters wrap modulo 2^32 and are cleared by rst.
- When undefined: all three counters are tied to 0, no counter flops exist, and the port list is unchanged.

Test Plan:
- Reset then stream: in_valid=1, in_data=0x100,0x104,0x108 on consecutive cycles (STAGES=4) -> out_data=0x100 exactly 4 cycles after first acceptance, then 0x104, 0x108; stage_valid walks 0001->0011->0111->1111.
- Load-use stall: full pipe with 0x10,0x14,0x18,0x1C (stage 0..3), hold_en=1, hold_idx=1 for 1 cycle -> stage0=0x10 kept, stage1 valid=0 data=0, stage2=0x14, stage3=0x18; in_ready=0 that cycle; bubble_cnt=1 (macro on).
- Branch flush: full pipe, flush_en=1, flush_idx=1 -> stages 0,1 invalid with data 0, stages 2,3 advance normally; killed_cnt=2.
- Flush and hold together: flush_idx=0, hold_idx=2 -> stage0 cleared, stage1 holds, stage2 bubble, stage3 takes the old stage2 contents.
- Out-of-range hold: hold_idx=3 with STAGES=3 -> all stages frozen, out_valid stable, retired_cnt unchanged.
- Reset mid-stream: rst=1 with pipe full and flush_en=1 -> next cycle all valid=0, data=0, counters 0; with PIPE_PERF_CNT_EN undefined, counters read 0 throughout the bench.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Parametrised valid+payload pipeline register chain with indexed hold/bubble and flush.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int IDXW   = ($clog2(STAGES) < 1) ? 1 : $clog2(STAGES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      hold_en,
    input  logic [IDXW-1:0]           hold_idx,
    input  logic                      flush_en,
    input  logic [IDXW-1:0]           flush_idx,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [31:0]               retired_cnt,
    output logic [31:0]               bubble_cnt,
    output logic [31:0]               killed_cnt
);

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] valid_nxt_s;
    logic [STAGES-1:0] src_valid_s;
    logic [STAGES-1:0] flush_hit_s;
    logic [STAGES-1:0] hold_hit_s;
    logic [STAGES-1:0] bubble_hit_s;
    logic [WIDTH-1:0]  data_r     [STAGES];
    logic [WIDTH-1:0]  data_nxt_s [STAGES];
    logic [WIDTH-1:0]  src_data_s [STAGES];
    logic [31:0]       flush_lim_s;
    logic [31:0]       hold_lim_s;

    assign flush_lim_s = 32'(flush_idx);
    assign hold_lim_s  = 32'(hold_idx);

    // Stage 0 is fed from the input port, every other stage from its younger neighbour.
    always_comb begin
        src_valid_s   = {valid_r[STAGES-2:0], in_valid};
        src_data_s[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_data_s[i] = data_r[i-1];
        end
    end

    // Per-stage priority: flush, then hold, then bubble, then advance.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int i = 0; i < STAGES; i++) begin
            flush_hit_s[i]  = flush_en && ($unsigned(i) <= flush_lim_s);
            hold_hit_s[i]   = hold_en && ($unsigned(i) < hold_lim_s);
            bubble_hit_s[i] = hold_en && ($unsigned(i) == hold_lim_s);
            data_nxt_s[i]   = data_r[i];
            if (flush_hit_s[i] || (!hold_hit_s[i] && bubble_hit_s[i])) begin
                valid_nxt_s[i] = 1'b0;
                data_nxt_s[i]  = {WIDTH{1'b0}};
            end else if (hold_hit_s[i]) begin
                valid_nxt_s[i] = valid_r[i];
                data_nxt_s[i]  = data_r[i];
            end else begin
                valid_nxt_s[i] = src_valid_s[i];
                data_nxt_s[i]  = src_valid_s[i] ? src_data_s[i] : {WIDTH{1'b0}};
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_r <= valid_nxt_s;
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= data_nxt_s[i];
            end
        end
    end

    assign in_ready    = ~rst & ~hold_en & ~flush_en;
    assign stage_valid = valid_r;
    assign out_valid   = valid_r[STAGES-1];
    assign out_data    = data_r[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_flat
        assign stage_data[g*WIDTH +: WIDTH] = data_r[g];
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] retired_r;
    logic [31:0] bubble_r;
    logic [31:0] killed_r;
    logic [31:0] killed_add_s;
    logic        retire_s;
    logic        bubble_s;

    // Count valid stages destroyed by this cycle's flush; bubble overlapped by flush is not counted.
    always_comb begin
        killed_add_s = 32'd0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_hit_s[i] && valid_r[i]) begin
                killed_add_s = killed_add_s + 32'd1;
            end else begin
                killed_add_s = killed_add_s;
            end
        end
        retire_s = valid_r[STAGES-1] & ~hold_hit_s[STAGES-1] & ~flush_hit_s[STAGES-1];
        bubble_s = hold_en && (hold_lim_s < 32'(STAGES)) &&
                   !(flush_en && (flush_lim_s >= hold_lim_s));
    end

    // Wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= 32'd0;
            bubble_r  <= 32'd0;
            killed_r  <= 32'd0;
        end else begin
            retired_r <= retired_r + {31'd0, retire_s};
            bubble_r  <= bubble_r + {31'd0, bubble_s};
            killed_r  <= killed_r + killed_add_s;
        end
    end

    assign retired_cnt = retired_r;
    assign bubble_cnt  = bubble_r;
    assign killed_cnt  = killed_r;
`else
    assign retired_cnt = 32'd0;
    assign bubble_cnt  = 32'd0;
    assign killed_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a 4-stage and a 3-stage instance share one stimulus stream.
module tb_pipe_stage_chain;

`ifdef PIPE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        hold_en;
    logic [1:0]  hold_idx;
    logic        flush_en;
    logic [1:0]  flush_idx;

    logic         rdy4, ov4;
    logic [3:0]   sv4;
    logic [127:0] sd4;
    logic [31:0]  od4, ret4, bub4, kil4;
    logic         rdy3, ov3;
    logic [2:0]   sv3;
    logic [95:0]  sd3;
    logic [31:0]  od3, ret3, bub3, kil3;

    int vectors = 0;
    int miscompares = 0;

    pipe_stage_chain #(.STAGES(4), .WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy4),
        .hold_en(hold_en), .hold_idx(hold_idx), .flush_en(flush_en), .flush_idx(flush_idx),
        .stage_valid(sv4), .stage_data(sd4), .out_valid(ov4), .out_data(od4),
        .retired_cnt(ret4), .bubble_cnt(bub4), .killed_cnt(kil4)
    );

    pipe_stage_chain #(.STAGES(3), .WIDTH(32)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy3),
        .hold_en(hold_en), .hold_idx(hold_idx), .flush_en(flush_en), .flush_idx(flush_idx),
        .stage_valid(sv3), .stage_data(sd3), .out_valid(ov3), .out_data(od3),
        .retired_cnt(ret3), .bubble_cnt(bub3), .killed_cnt(kil3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset, then load 0x1C,0x18,0x14,0x10 so dut4 stages 0..3 hold 0x10,0x14,0x18,0x1C.
    task automatic fill();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0;
        hold_en = 1'b0; hold_idx = 2'd0; flush_en = 1'b0; flush_idx = 2'd0;
        tick();
        rst = 1'b0; in_valid = 1'b1;
        in_data = 32'h1C; tick();
        in_data = 32'h18; tick();
        in_data = 32'h14; tick();
        in_data = 32'h10; tick();
        in_valid = 1'b0; in_data = 32'h0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        hold_en = 1'b0; hold_idx = 2'd0; flush_en = 1'b0; flush_idx = 2'd0;
        #1;
        check("ready_in_rst", {127'd0, rdy4}, 128'd0);
        tick(); tick();
        check("rst_valid", {124'd0, sv4}, 128'd0);
        check("rst_data", sd4, 128'd0);
        check("rst_cnt", {32'd0, ret4, bub4, kil4}, 128'd0);

        // Streaming: stage_valid walks up, first item emerges after 4 edges
        rst = 1'b0; in_valid = 1'b1;
        #1;
        check("ready_idle", {127'd0, rdy4}, 128'd1);
        in_data = 32'h100; tick();
        check("walk1", {124'd0, sv4}, 128'h1);
        in_data = 32'h104; tick();
        check("walk2", {124'd0, sv4}, 128'h3);
        in_data = 32'h108; tick();
        check("walk3", {124'd0, sv4}, 128'h7);
        check("walk3_out", {127'd0, ov4}, 128'd0);
        in_data = 32'h10C; tick();
        check("walk4", {124'd0, sv4}, 128'hF);
        check("out_100", {96'd0, od4}, 128'h100);
        in_data = 32'h110; tick();
        check("out_104", {96'd0, od4}, 128'h104);
        in_data = 32'h114; tick();
        check("out_108", {96'd0, od4}, 128'h108);
        check("stream_data", sd4, {32'h108, 32'h10C, 32'h110, 32'h114});
        check("stream_ret", {96'd0, ret4}, 128'(2 * PERF));

        // Load-use stall: hold_idx=1 keeps stage 0, bubbles stage 1
        fill();
        check("fill_data", sd4, {32'h1C, 32'h18, 32'h14, 32'h10});
        hold_en = 1'b1; hold_idx = 2'd1; in_valid = 1'b1; in_data = 32'hDEAD;
        #1;
        check("ready_hold", {127'd0, rdy4}, 128'd0);
        tick();
        hold_en = 1'b0; in_valid = 1'b0;
        check("stall_valid", {124'd0, sv4}, 128'hD);
        check("stall_data", sd4, {32'h18, 32'h14, 32'h0, 32'h10});
        check("stall_bub", {96'd0, bub4}, 128'(PERF));
        check("stall_ret", {96'd0, ret4}, 128'(PERF));

        // Branch flush of stages 0..1
        fill();
        flush_en = 1'b1; flush_idx = 2'd1; in_valid = 1'b1; in_data = 32'hBEEF;
        #1;
        check("ready_flush", {127'd0, rdy4}, 128'd0);
        tick();
        flush_en = 1'b0; in_valid = 1'b0;
        check("flush_valid", {124'd0, sv4}, 128'hC);
        check("flush_data", sd4, {32'h18, 32'h14, 32'h0, 32'h0});
        check("flush_kill", {96'd0, kil4}, 128'(2 * PERF));
        check("flush_bub", {96'd0, bub4}, 128'd0);

        // Flush and hold together
        fill();
        flush_en = 1'b1; flush_idx = 2'd0; hold_en = 1'b1; hold_idx = 2'd2;
        tick();
        flush_en = 1'b0; hold_en = 1'b0;
        check("fh_valid", {124'd0, sv4}, 128'hA);
        check("fh_data", sd4, {32'h18, 32'h0, 32'h14, 32'h0});
        check("fh_cnt", {32'd0, ret4, bub4, kil4}, {32'd0, 32'(PERF), 32'(PERF), 32'(PERF)});

        // Out-of-range hold on the 3-stage instance freezes everything
        fill();
        check("d3_fill", {32'd0, sd3}, {32'd0, 32'h18, 32'h14, 32'h10});
        check("d3_ret_fill", {96'd0, ret3}, 128'(PERF));
        hold_en = 1'b1; hold_idx = 2'd3;
        tick(); tick();
        check("d3_hold_valid", {125'd0, sv3}, 128'h7);
        check("d3_hold_data", {32'd0, sd3}, {32'd0, 32'h18, 32'h14, 32'h10});
        check("d3_hold_out", {96'd0, od3}, 128'h18);
        check("d3_hold_cnt", {32'd0, ret3, bub3, kil3}, {32'd0, 32'(PERF), 32'd0, 32'd0});
        check("d4_hold_valid", {124'd0, sv4}, 128'h7);
        check("d4_hold_cnt", {32'd0, ret4, bub4, kil4}, {32'd0, 32'(PERF), 32'(2 * PERF), 32'd0});

        // Flush index beyond the 3-stage depth clears every stage
        hold_en = 1'b0; flush_en = 1'b1; flush_idx = 2'd3;
        tick();
        flush_en = 1'b0;
        check("d3_flushall", {29'd0, sv3, sd3}, 128'd0);
        check("d3_kill", {96'd0, kil3}, 128'(3 * PERF));
        check("d4_flushall", {124'd0, sv4}, 128'd0);
        check("d4_kill", {96'd0, kil4}, 128'(3 * PERF));

        // Reset mid-stream overrides a simultaneous flush
        fill();
        in_valid = 1'b1; in_data = 32'h55; flush_en = 1'b1; flush_idx = 2'd1; rst = 1'b1;
        #1;
        check("ready_rst_flush", {127'd0, rdy4}, 128'd0);
        tick();
        rst = 1'b0; flush_en = 1'b0; in_valid = 1'b0;
        check("mrst_state", {124'd0, sv4} | sd4, 128'd0);
        check("mrst_cnt", {32'd0, ret4, bub4, kil4}, 128'd0);
        check("mrst_d3", {29'd0, sv3, sd3}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
